// File: rtl/aom_dac_spi_drv.sv
// Serial driver for the AOM amplitude DAC: buffers one pending code and shifts
// 24-bit write frames out MSB-first. Define AOM_DAC_LDAC_EN to add an LDAC_N pulse after each frame.
module aom_dac_spi_drv #(
   parameter real        TCQ     = 0.1,
   parameter int         CLK_DIV = 4,
   parameter int         GAP_CYC = 8,
   parameter logic [3:0] DAC_CMD = 4'b0011
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        aom_en_i,
   input  logic [11:0] aom_voltage_i,
   output logic        dac_busy_o,
   output logic        dac_done_o,
   output logic [15:0] dac_ovwr_cnt_o,
   output logic [11:0] dac_last_code_o,
   output logic        DAC_SYNC_N,
   output logic        DAC_SCLK,
   output logic        DAC_SDIN,
   output logic        DAC_LDAC_N
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
`ifdef AOM_DAC_LDAC_EN
   localparam logic [2:0] ST_LDAC  = 3'd4;
   localparam logic [3:0] CMD_NIB  = 4'b0001;
`else
   localparam logic [3:0] CMD_NIB  = DAC_CMD;
`endif
   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

   // TCQ only shapes simulation timing in older models; kept for interface compatibility.
   logic unused_tcq;
   assign unused_tcq = (TCQ > 0.0);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [23:0] build_frame(input logic [11:0] code);
      return {CMD_NIB, 4'b0000, code, 4'b0000};
   endfunction

   logic [2:0]  state_q, state_d;
   logic        pend_vld_q, pend_vld_d;
   logic [11:0] pend_code_q, pend_code_d;
   logic [11:0] code_q, code_d;
   logic [23:0] shreg_q, shreg_d;
   logic [7:0]  half_q, half_d;
   logic [4:0]  bit_q, bit_d;
   logic [15:0] ovwr_q, ovwr_d;
   logic [11:0] last_q, last_d;
   logic        sync_n_q, sync_n_d;
   logic        sclk_q, sclk_d;
   logic        sdin_q, sdin_d;
   logic        consume;
   logic [23:0] frame_w;
`ifdef AOM_DAC_LDAC_EN
   logic        ldac_n_q, ldac_n_d;
   logic [3:0]  unused_cmd;
   assign unused_cmd = DAC_CMD;
`endif

   assign consume = (state_q == ST_IDLE) && pend_vld_q;
   assign frame_w = build_frame(code_q);

   always_comb begin
      state_d     = state_q;
      pend_vld_d  = pend_vld_q;
      pend_code_d = pend_code_q;
      code_d      = code_q;
      shreg_d     = shreg_q;
      half_d      = half_q;
      bit_d       = bit_q;
      ovwr_d      = ovwr_q;
      last_d      = last_q;
      sync_n_d    = sync_n_q;
      sclk_d      = sclk_q;
      sdin_d      = sdin_q;
`ifdef AOM_DAC_LDAC_EN
      ldac_n_d    = ldac_n_q;
`endif

      // A request arriving while IDLE drains the buffer refills it without loss.
      if (aom_en_i) begin
         pend_vld_d  = 1'b1;
         pend_code_d = aom_voltage_i;
         if (pend_vld_q && !consume) ovwr_d = sat_inc(ovwr_q);
      end else if (consume) begin
         pend_vld_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (pend_vld_q) begin
               state_d  = ST_LOAD;
               code_d   = pend_code_q;
               sync_n_d = 1'b0;
            end
         end
         ST_LOAD: begin
            shreg_d = frame_w;
            sdin_d  = frame_w[23];
            sclk_d  = 1'b1;
            half_d  = 8'd0;
            bit_d   = 5'd0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (half_q == HALF_LAST) begin
               half_d = 8'd0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
               end else if (bit_q == 5'd23) begin
                  state_d  = ST_GAP;
                  sync_n_d = 1'b1;
                  sclk_d   = 1'b1;
                  sdin_d   = 1'b0;
                  last_d   = code_q;
               end else begin
                  bit_d   = bit_q + 5'd1;
                  sclk_d  = 1'b1;
                  sdin_d  = shreg_q[22];
                  shreg_d = {shreg_q[22:0], 1'b0};
               end
            end else begin
               half_d = half_q + 8'd1;
            end
         end
         ST_GAP: begin
            if (half_q == GAP_LAST) begin
               half_d = 8'd0;
`ifdef AOM_DAC_LDAC_EN
               state_d  = ST_LDAC;
               ldac_n_d = 1'b0;
`else
               state_d  = ST_IDLE;
`endif
            end else begin
               half_d = half_q + 8'd1;
            end
         end
`ifdef AOM_DAC_LDAC_EN
         ST_LDAC: begin
            if (half_q == HALF_LAST) begin
               half_d   = 8'd0;
               ldac_n_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               half_d = half_q + 8'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         pend_vld_q <= 1'b0;
         half_q     <= 8'd0;
         bit_q      <= 5'd0;
         ovwr_q     <= 16'd0;
         last_q     <= 12'd0;
         sync_n_q   <= 1'b1;
         sclk_q     <= 1'b1;
         sdin_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         ovwr_q     <= ovwr_d;
         last_q     <= last_d;
         sync_n_q   <= sync_n_d;
         sclk_q     <= sclk_d;
         sdin_q     <= sdin_d;
      end
   end

   // Data holding registers are qualified by pend_vld/state and need no reset.
   always_ff @(posedge clk_i) begin
      pend_code_q <= pend_code_d;
      code_q      <= code_d;
      shreg_q     <= shreg_d;
   end

`ifdef AOM_DAC_LDAC_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) ldac_n_q <= 1'b1;
      else       ldac_n_q <= ldac_n_d;
   end
   assign DAC_LDAC_N = ldac_n_q;
   assign dac_done_o = (state_q == ST_LDAC) && (half_q == HALF_LAST);
`else
   assign DAC_LDAC_N = 1'b1;
   assign dac_done_o = (state_q == ST_GAP) && (half_q == GAP_LAST);
`endif

   assign dac_busy_o      = pend_vld_q || (state_q != ST_IDLE);
   assign dac_ovwr_cnt_o  = ovwr_q;
   assign dac_last_code_o = last_q;
   assign DAC_SYNC_N      = sync_n_q;
   assign DAC_SCLK        = sclk_q;
   assign DAC_SDIN        = sdin_q;

endmodule

// File: tb/tb_aom_dac_spi_drv.sv
// Directed bench for aom_dac_spi_drv: a monitor decodes each serial frame and
// matches it against a queue of expected frames filled as requests are issued.
module tb_aom_dac_spi_drv;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        aom_en_i;
   logic [11:0] aom_voltage_i;
   logic        dac_busy_o, dac_done_o;
   logic [15:0] dac_ovwr_cnt_o;
   logic [11:0] dac_last_code_o;
   logic        DAC_SYNC_N, DAC_SCLK, DAC_SDIN, DAC_LDAC_N;

`ifdef AOM_DAC_LDAC_EN
   localparam logic [3:0] TB_CMD = 4'b0001;
   localparam int DONE_K = 2 + 193 + 8 + 4 - 1;
   localparam int LDAC_LOW = 4;
`else
   localparam logic [3:0] TB_CMD = 4'b0011;
   localparam int DONE_K = 2 + 193 + 8 - 1;
   localparam int LDAC_LOW = 0;
`endif

   aom_dac_spi_drv dut (
      .clk_i(clk), .rst_i(rst_i), .aom_en_i(aom_en_i), .aom_voltage_i(aom_voltage_i),
      .dac_busy_o(dac_busy_o), .dac_done_o(dac_done_o), .dac_ovwr_cnt_o(dac_ovwr_cnt_o),
      .dac_last_code_o(dac_last_code_o), .DAC_SYNC_N(DAC_SYNC_N), .DAC_SCLK(DAC_SCLK),
      .DAC_SDIN(DAC_SDIN), .DAC_LDAC_N(DAC_LDAC_N)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_q[$];
   int          frames = 0;
   int          dones = 0;
   bit          sb_off = 1'b0;
   bit          abort_ok = 1'b0;

   int first_low, low_cnt, done_k, done_n, ldac_low, ldac_first;
   logic busy_k1, busy_done, busy_after;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [23:0] frm(input logic [11:0] c);
      return {TB_CMD, 4'h0, c, 4'h0};
   endfunction

   // Frame monitor: shift SDIN on each SCLK fall while SYNC_N is low.
   bit          in_frame = 1'b0;
   int          nbits = 0;
   logic [23:0] mshr = 24'd0;
   logic        prev_sclk = 1'b1;
   always @(negedge clk) begin
      if (DAC_SYNC_N === 1'b0) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            nbits = 0;
         end
         if (prev_sclk === 1'b1 && DAC_SCLK === 1'b0) begin
            mshr = {mshr[22:0], DAC_SDIN};
            nbits++;
         end
      end else if (in_frame) begin
         in_frame = 1'b0;
         if (nbits == 24) begin
            frames++;
            if (!sb_off) begin
               if (exp_q.size() == 0) check("frame_unexpected", 32'(mshr), 32'hFFFFFFFF);
               else check("frame", 32'(mshr), 32'(exp_q.pop_front()));
            end
         end else begin
            check("frame_abort_ok", 32'(abort_ok), 32'd1);
         end
      end
      prev_sclk = DAC_SCLK;
      if (dac_done_o === 1'b1) dones++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [11:0] c);
      aom_en_i = 1'b1;
      aom_voltage_i = c;
      tick();
      aom_en_i = 1'b0;
   endtask

   task automatic wait_sync_low(input string tag);
      int n = 0;
      while (DAC_SYNC_N !== 1'b0 && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) check(tag, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (dac_busy_o !== 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) check(tag, 32'd0, 32'd1);
   endtask

   // Issue one request from idle and record frame timing relative to the request cycle.
   task automatic run_one(input logic [11:0] c);
      first_low = -1; low_cnt = 0; done_k = -1; done_n = 0; ldac_low = 0; ldac_first = -1;
      exp_q.push_back(frm(c));
      aom_voltage_i = c;
      aom_en_i = 1'b1;
      for (int k = 1; k <= 260; k++) begin
         tick();
         aom_en_i = 1'b0;
         if (DAC_SYNC_N === 1'b0) begin
            if (first_low < 0) first_low = k;
            low_cnt++;
         end
         if (dac_done_o === 1'b1) begin
            done_k = k;
            done_n++;
         end
         if (DAC_LDAC_N === 1'b0) begin
            if (ldac_first < 0) ldac_first = k;
            ldac_low++;
         end
         if (k == 1) busy_k1 = dac_busy_o;
         if (k == DONE_K) busy_done = dac_busy_o;
         if (k == DONE_K + 1) busy_after = dac_busy_o;
      end
   endtask

   initial begin
      int f0, d0, n;
      rst_i = 1'b1;
      aom_en_i = 1'b0;
      aom_voltage_i = 12'h000;
      tick();
      tick();
      aom_voltage_i = 12'h555;
      aom_en_i = 1'b1;
      tick();
      aom_en_i = 1'b0;
      check("rst_sync_n", 32'(DAC_SYNC_N), 32'd1);
      check("rst_sclk", 32'(DAC_SCLK), 32'd1);
      check("rst_sdin", 32'(DAC_SDIN), 32'd0);
      check("rst_ldac_n", 32'(DAC_LDAC_N), 32'd1);
      check("rst_busy", 32'(dac_busy_o), 32'd0);
      check("rst_done", 32'(dac_done_o), 32'd0);
      check("rst_ovwr", 32'(dac_ovwr_cnt_o), 32'd0);
      check("rst_last", 32'(dac_last_code_o), 32'd0);
      rst_i = 1'b0;
      tick();
      tick();
      check("rst_req_ignored_busy", 32'(dac_busy_o), 32'd0);

      // Basic frame timing for 12'hABC.
      run_one(12'hABC);
      check("t1_sync_fall_k", 32'(first_low), 32'd2);
      check("t1_sync_low_len", 32'(low_cnt), 32'd193);
      check("t1_done_k", 32'(done_k), 32'(DONE_K));
      check("t1_done_count", 32'(done_n), 32'd1);
      check("t1_ldac_low", 32'(ldac_low), 32'(LDAC_LOW));
      check("t1_busy_start", 32'(busy_k1), 32'd1);
      check("t1_busy_at_done", 32'(busy_done), 32'd1);
      check("t1_busy_after", 32'(busy_after), 32'd0);
      check("t1_last_code", 32'(dac_last_code_o), 32'h0ABC);
      check("t1_frames", 32'(frames), 32'd1);

      // Two requests during a frame: the later one wins and one overwrite is counted.
      f0 = frames; d0 = dones;
      exp_q.push_back(frm(12'h100));
      req(12'h100);
      wait_sync_low("t2_wait_sync");
      exp_q.push_back(frm(12'h200));
      req(12'h200);
      check("t2_ovwr_fill", 32'(dac_ovwr_cnt_o), 32'd0);
      exp_q[exp_q.size() - 1] = frm(12'h300);
      req(12'h300);
      check("t2_ovwr_one", 32'(dac_ovwr_cnt_o), 32'd1);
      wait_idle("t2_wait_idle");
      check("t2_frames", 32'(frames - f0), 32'd2);
      check("t2_dones", 32'(dones - d0), 32'd2);
      check("t2_last_code", 32'(dac_last_code_o), 32'h0300);

      // Back-to-back requests: the second lands in the cycle IDLE drains the buffer.
      f0 = frames;
      exp_q.push_back(frm(12'h111));
      exp_q.push_back(frm(12'h222));
      aom_voltage_i = 12'h111;
      aom_en_i = 1'b1;
      tick();
      aom_voltage_i = 12'h222;
      tick();
      aom_en_i = 1'b0;
      check("t3_no_ovwr", 32'(dac_ovwr_cnt_o), 32'd1);
      wait_idle("t3_wait_idle");
      check("t3_frames", 32'(frames - f0), 32'd2);
      check("t3_last_code", 32'(dac_last_code_o), 32'h0222);

      // Reset in the middle of bit 10 aborts the frame.
      f0 = frames;
      exp_q.push_back(frm(12'h456));
      req(12'h456);
      wait_sync_low("t4_wait_sync");
      n = 0;
      begin
         int falls = 0;
         logic ps = DAC_SCLK;
         while (falls < 10 && n < 1000) begin
            tick();
            n++;
            if (ps === 1'b1 && DAC_SCLK === 1'b0) falls++;
            ps = DAC_SCLK;
         end
         while (DAC_SCLK !== 1'b1 && n < 1000) begin
            tick();
            n++;
         end
      end
      if (n >= 1000) check("t4_bit10_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      abort_ok = 1'b1;
      d0 = dones;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("t4_sync_n", 32'(DAC_SYNC_N), 32'd1);
      check("t4_sclk", 32'(DAC_SCLK), 32'd1);
      check("t4_sdin", 32'(DAC_SDIN), 32'd0);
      check("t4_busy", 32'(dac_busy_o), 32'd0);
      check("t4_done", 32'(dac_done_o), 32'd0);
      check("t4_ovwr", 32'(dac_ovwr_cnt_o), 32'd0);
      check("t4_last", 32'(dac_last_code_o), 32'd0);
      tick();
      tick();
      abort_ok = 1'b0;
      check("t4_no_done", 32'(dones - d0), 32'd0);
      check("t4_aborted_not_counted", 32'(frames - f0), 32'd0);
      exp_q.push_back(frm(12'h789));
      req(12'h789);
      wait_sync_low("t4_wait_sync2");
      wait_idle("t4_wait_idle");
      check("t4_frames_after", 32'(frames - f0), 32'd1);
      check("t4_dones_after", 32'(dones - d0), 32'd1);
      check("t4_last_after", 32'(dac_last_code_o), 32'h0789);

`ifdef AOM_DAC_LDAC_EN
      run_one(12'h7FF);
      check("t5_ldac_first", 32'(ldac_first), 32'd203);
      check("t5_ldac_len", 32'(ldac_low), 32'd4);
      check("t5_done_k", 32'(done_k), 32'd206);
      check("t5_last_code", 32'(dac_last_code_o), 32'h07FF);
`endif

      // Drive the overwrite counter up to 16'hFFFE, then saturate it.
      sb_off = 1'b1;
      aom_en_i = 1'b1;
      n = 0;
      while (dac_ovwr_cnt_o !== 16'hFFFE && n < 70000) begin
         aom_voltage_i = 12'($urandom);
         tick();
         n++;
      end
      aom_en_i = 1'b0;
      if (n >= 70000) check("t6_reach_fffe", 32'd0, 32'd1);
      wait_idle("t6_wait_idle0");
      sb_off = 1'b0;
      exp_q.delete();
      exp_q.push_back(frm(12'hA01));
      req(12'hA01);
      wait_sync_low("t6_wait_sync");
      exp_q.push_back(frm(12'hA02));
      req(12'hA02);
      check("t6_ovwr_fffe", 32'(dac_ovwr_cnt_o), 32'h0000FFFE);
      exp_q[exp_q.size() - 1] = frm(12'hA03);
      req(12'hA03);
      check("t6_ovwr_ffff", 32'(dac_ovwr_cnt_o), 32'h0000FFFF);
      exp_q[exp_q.size() - 1] = frm(12'hA04);
      req(12'hA04);
      check("t6_ovwr_sat1", 32'(dac_ovwr_cnt_o), 32'h0000FFFF);
      exp_q[exp_q.size() - 1] = frm(12'hA05);
      req(12'hA05);
      check("t6_ovwr_sat2", 32'(dac_ovwr_cnt_o), 32'h0000FFFF);
      wait_idle("t6_wait_idle");
      check("t6_last_code", 32'(dac_last_code_o), 32'h0A05);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aom_dac_spi_drv.md
AOM_DAC_SPI_DRV -- requirements
Module: aom_dac_spi_drv

Interface
REQ-001 The module SHALL have the parameter TCQ, default 0.1, the register-update delay used in simulation.
REQ-002 The module SHALL have the parameter CLK_DIV, default 4, giving the clk_i cycles per SCLK half-period (legal range 1..255).
REQ-003 The module SHALL have the parameter GAP_CYC, default 8, giving the minimum clk_i cycles DAC_SYNC_N stays high between frames (legal range 1..255).
REQ-004 The module SHALL have the parameter DAC_CMD, default 4'b0011, the command nibble meaning "write and update".
REQ-005 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous to clk_i and active-high.
REQ-007 aom_en_i  input  1  one-cycle write request from the AOM control stage.
REQ-008 aom_voltage_i  input  12  DAC code, sampled in the cycle where aom_en_i=1.
REQ-009 dac_busy_o  output  1  high from the request capture until the GAP state completes.
REQ-010 dac_done_o  output  1  one-cycle pulse when a frame's GAP state completes.
REQ-011 dac_ovwr_cnt_o  output  16  saturating count of pending requests that were overwritten.
REQ-012 dac_last_code_o  output  12  code of the most recently completed frame.
REQ-013 DAC_SYNC_N, DAC_SCLK, DAC_SDIN, DAC_LDAC_N  output  1 each  serial DAC pins.

Function
REQ-014 The module SHALL hold a 1-entry pending register (pend_vld, pend_code); aom_en_i=1 SHALL load aom_voltage_i into it and set pend_vld.
REQ-015 If aom_en_i=1 while pend_vld=1 and the pending entry is not consumed in the same cycle, the module SHALL overwrite pend_code and increment dac_ovwr_cnt_o, saturating at 16'hFFFF.
REQ-016 The states SHALL be IDLE, LOAD, SHIFT, GAP and LDAC (LDAC exists only per REQ-027).
REQ-017 In IDLE with pend_vld=1, the module SHALL go to LOAD and clear pend_vld in the same cycle; an aom_en_i in that cycle SHALL refill the pending register without counting as an overwrite.
REQ-018 LOAD SHALL last 1 cycle: it builds the 24-bit frame {DAC_CMD, 4'b0000, code, 4'b0000}, drives DAC_SYNC_N low, and enters SHIFT.
REQ-019 In SHIFT, each bit SHALL take 2*CLK_DIV cycles: SCLK high with SDIN updated to the next MSB-first bit for CLK_DIV cycles, then SCLK low for CLK_DIV cycles, so the DAC samples on the falling edge.
REQ-020 After the 24th low half-period, the module SHALL raise DAC_SYNC_N and SCLK, update dac_last_code_o, and enter GAP.
REQ-021 GAP SHALL last GAP_CYC cycles; on its last cycle the module SHALL pulse dac_done_o and return to IDLE.
REQ-022 A request in IDLE therefore SHALL see DAC_SYNC_N fall 2 cycles after aom_en_i, and DAC_SYNC_N SHALL stay low for exactly 1+48*CLK_DIV cycles.
REQ-023 Idle levels SHALL be: DAC_SYNC_N=1, DAC_SCLK=1, DAC_SDIN=0, DAC_LDAC_N=1.
REQ-024 The bit counter SHALL be 5 bits and the half-period counter 8 bits; neither SHALL wrap during a frame.

Reset
REQ-025 While rst_i=1, the state SHALL be IDLE, pend_vld 0, counters 0, dac_ovwr_cnt_o 0, dac_last_code_o 0, dac_busy_o 0, dac_done_o 0, and the DAC pins at their REQ-023 levels.
REQ-026 rst_i asserted mid-frame SHALL abort the frame on the next edge (DAC_SYNC_N high, no dac_done_o), and an aom_en_i in a reset cycle SHALL be ignored.

Configuration
REQ-027 With AOM_DAC_LDAC_EN defined, the GAP state SHALL be followed by an LDAC state that drives DAC_LDAC_N low for CLK_DIV cycles, and dac_done_o SHALL move to the last LDAC cycle; the frame command nibble SHALL then be 4'b0001 (write input register only).
REQ-028 Without AOM_DAC_LDAC_EN, DAC_LDAC_N SHALL be constant 1, the LDAC state SHALL be absent, and DAC_CMD SHALL apply.

Verification
REQ-029 Reset, then aom_en_i=1 with code 12'hABC (CLK_DIV=4) -> SYNC_N falls at +2 cycles; SDIN carries 0x30ABC0 MSB-first over 24 SCLK falls; SYNC_N low for 193 cycles; dac_done_o at +2+193+8-1; dac_last_code_o=12'hABC.
REQ-030 Request 12'h100, then 12'h200 and 12'h300 during the first frame -> second frame carries 12'h300; dac_ovwr_cnt_o=1; exactly two frames are sent.
REQ-031 aom_en_i in the same cycle IDLE consumes the pending entry -> no overwrite is counted; that code goes out in the next frame.
REQ-032 rst_i pulsed at bit 10 of a frame -> SYNC_N high next cycle; no dac_done_o; all outputs at reset values; a request 3 cycles later produces a full normal frame.
REQ-033 Force dac_ovwr_cnt_o to 16'hFFFE and apply 3 overwrites -> the count holds at 16'hFFFF.
REQ-034 With AOM_DAC_LDAC_EN defined and code 12'h7FF -> command nibble 4'b0001; LDAC_N low for 4 cycles after GAP; dac_done_o on the last LDAC cycle.
